constant_coeff_scaler: RTL and testbench

- Multi-channel, pipelined constant-coefficient multiplier with a valid/ready handshake.
- Per transaction, one coefficient is selected from a parameter table and applied to all NUM_CH signed samples.
- Each product is scaled by FRAC_BITS with optional rounding, then saturated to dataWidth_o.
- Sits between feature-map buffers and the activation-function stage; it is the generalised, flow-controlled successor of the single-constant multiplier.

---
 rtl/constant_coeff_scaler.sv | 140 ++++++++++++++
 tb/tb_constant_coeff_scaler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/constant_coeff_scaler.sv
// Multi-channel constant-coefficient multiplier: a table coefficient scales every
// channel of a beat, then each product is shifted, optionally rounded and saturated.
module constant_coeff_scaler #(
  parameter int dataWidth_i = 10,
  parameter int COEFF_W     = 8,
  parameter int NUM_CH      = 2,
  parameter int NUM_COEFF   = 4,
  parameter logic [NUM_COEFF*COEFF_W-1:0] COEFF_TABLE = {8'sd127, 8'sd64, -8'sd30, 8'sd30},
  parameter int FRAC_BITS   = 4,
  parameter int ROUND_MODE  = 1,
  parameter int dataWidth_o = 12,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic [NUM_CH*dataWidth_i-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*dataWidth_o-1:0] out_data,
  output logic [NUM_CH-1:0]             out_sat,
  input  logic                          sat_clr,
  output logic [CNT_W-1:0]              sat_count
);

  localparam int PROD_W = dataWidth_i + COEFF_W;
  // One extra bit so the rounding add can never wrap.
  localparam int SUM_W  = PROD_W + 1;
  localparam int LUT_N  = 1 << SEL_W;
  localparam int RND_INT = (ROUND_MODE != 0 && FRAC_BITS > 0) ?
                           (1 << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : 0;
  localparam logic signed [SUM_W-1:0] RND_ADD = SUM_W'(RND_INT);
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << (dataWidth_o - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam int POP_W  = $clog2(NUM_CH + 1);
  localparam int CSUM_W = CNT_W + POP_W;

  // Handshake: a beat moves on a rising edge when valid and ready are both high in
  // that cycle. Every stage advances together whenever the output slot is empty or
  // being drained (en); otherwise the whole pipeline holds, keeping the output stable.
  logic en;
  logic out_hs;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign out_hs   = out_valid & out_ready;

  // Unused indices fall back to entry 0, so an out-of-range select is harmless.
  logic signed [COEFF_W-1:0] coeff_lut [LUT_N];
  logic signed [COEFF_W-1:0] coeff;

  genvar k;
  for (k = 0; k < LUT_N; k++) begin : g_lut
    if (k < NUM_COEFF) begin : g_hit
      assign coeff_lut[k] = COEFF_TABLE[k*COEFF_W +: COEFF_W];
    end else begin : g_miss
      assign coeff_lut[k] = COEFF_TABLE[0 +: COEFF_W];
    end
  end

  assign coeff = coeff_lut[in_sel];

  logic signed [PROD_W-1:0]      prod    [NUM_CH];
  logic signed [PROD_W-1:0]      s1_prod [NUM_CH];
  logic                          s1_valid;
  logic        [dataWidth_o-1:0] res     [NUM_CH];
  logic        [NUM_CH-1:0]      sat_hi;
  logic        [NUM_CH-1:0]      sat_lo;

  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [dataWidth_i-1:0] sample;
    logic signed [SUM_W-1:0]       sum;
    logic signed [SUM_W-1:0]       shifted;

    assign sample  = in_data[c*dataWidth_i +: dataWidth_i];
    assign prod[c] = PROD_W'(sample) * PROD_W'(coeff);

    assign sum     = {s1_prod[c][PROD_W-1], s1_prod[c]} + RND_ADD;
    assign shifted = sum >>> FRAC_BITS;
    assign sat_hi[c] = shifted > OUT_MAX;
    assign sat_lo[c] = shifted < OUT_MIN;
    assign res[c] = sat_hi[c] ? OUT_MAX[dataWidth_o-1:0] :
                    sat_lo[c] ? OUT_MIN[dataWidth_o-1:0] :
                                shifted[dataWidth_o-1:0];
  end

  // S1 holds full-precision products, S2 holds the final scaled results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_prod[i] <= '0;
      end
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_prod[i] <= prod[i];
        out_data[i*dataWidth_o +: dataWidth_o] <= res[i];
        out_sat[i] <= sat_hi[i] | sat_lo[i];
      end
    end
  end

  logic [CSUM_W-1:0] sat_pop;
  logic [CSUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sat_pop = sat_pop + CSUM_W'(out_sat[i]);
    end
    cnt_sum = CSUM_W'(sat_count) + sat_pop;
    if (|cnt_sum[CSUM_W-1:CNT_W]) begin
      cnt_next = '1;
    end else begin
      cnt_next = cnt_sum[CNT_W-1:0];
    end
  end

  // A clear in the same cycle as a counted handshake wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_hs) begin
      sat_count <= cnt_next;
    end
  end

endmodule

// File: tb/tb_constant_coeff_scaler.sv
// Bench for constant_coeff_scaler: a rounding/16-bit-counter instance and a
// truncating/2-bit-counter instance with a wider table, driven in lockstep.
module tb_constant_coeff_scaler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_sel_a;
  logic [2:0]  in_sel_b;
  logic [19:0] in_data;
  logic        out_ready;
  logic        sat_clr;

  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [23:0] out_data_a, out_data_b;
  logic [1:0]  out_sat_a, out_sat_b;
  logic [15:0] sat_count_a;
  logic [1:0]  sat_count_b;

  int n_vec = 0;
  int n_bad = 0;

  // {b: sat, ch1, ch0 | a: sat, ch1, ch0}
  logic [51:0] exp_q[$];
  int exp_cnt_a, exp_cnt_b, inc_a, inc_b;
  logic [51:0] e;

  always #5 clk = ~clk;

  constant_coeff_scaler #(
    .dataWidth_i(10), .COEFF_W(8), .NUM_CH(2), .NUM_COEFF(4),
    .COEFF_TABLE({8'sd127, 8'sd64, -8'sd30, 8'sd30}),
    .FRAC_BITS(4), .ROUND_MODE(1), .dataWidth_o(12), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sel(in_sel_a), .in_data(in_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a),
    .sat_clr(sat_clr), .sat_count(sat_count_a)
  );

  constant_coeff_scaler #(
    .dataWidth_i(10), .COEFF_W(8), .NUM_CH(2), .NUM_COEFF(5),
    .COEFF_TABLE({-8'sd1, 8'sd127, 8'sd64, -8'sd30, 8'sd30}),
    .FRAC_BITS(4), .ROUND_MODE(0), .dataWidth_o(12), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sel(in_sel_b), .in_data(in_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b),
    .sat_clr(sat_clr), .sat_count(sat_count_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] pk(input int d0, input int d1, input logic [1:0] s);
    logic [11:0] x0, x1;
    x0 = d0[11:0];
    x1 = d1[11:0];
    return {s, x1, x0};
  endfunction

  // Call at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input int sel, input int a0, input int a1,
                      input logic [25:0] ea, input logic [25:0] eb);
    int t;
    in_sel_a = 2'(sel);
    in_sel_b = 3'(sel);
    in_data  = {10'(a1), 10'(a0)};
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready_a && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready_a) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
    end
    exp_q.push_back({eb, ea});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor and saturation-counter model.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt_a = 0;
      exp_cnt_b = 0;
    end else begin
      inc_a = 0;
      inc_b = 0;
      check("sat_count_a", 64'(sat_count_a), 64'(exp_cnt_a));
      check("sat_count_b", 64'(sat_count_b), 64'(exp_cnt_b));
      if (out_valid_a || out_valid_b) begin
        check("valid_pair", {out_valid_b, out_valid_a}, 2'b11);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_beat: out_valid=1 with data 0x%0h, expected no beat", out_data_a);
        end else begin
          e = exp_q[0];
          check("beat_a", {out_sat_a, out_data_a}, e[25:0]);
          check("beat_b", {out_sat_b, out_data_b}, e[51:26]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            inc_a = int'(e[25]) + int'(e[24]);
            inc_b = int'(e[51]) + int'(e[50]);
          end
        end
      end
      if (sat_clr) begin
        exp_cnt_a = 0;
        exp_cnt_b = 0;
      end else begin
        exp_cnt_a = (exp_cnt_a + inc_a > 65535) ? 65535 : exp_cnt_a + inc_a;
        exp_cnt_b = (exp_cnt_b + inc_b > 3) ? 3 : exp_cnt_b + inc_b;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel_a  = '0;
    in_sel_b  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_out_data", out_data_a, 24'h0);
    check("rst_out_sat", out_sat_a, 2'b00);
    check("rst_sat_count", sat_count_a, 16'h0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready_a, 1'b1);
    @(posedge clk);
    #1;

    // Rounding vs truncation, plus two-cycle latency.
    send(0, 100, -100, pk(188, -187, 2'b00), pk(187, -188, 2'b00));
    @(negedge clk);
    check("latency_early", out_valid_a, 1'b0);
    @(negedge clk);
    check("latency_on_time", out_valid_a, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Both channels saturate.
    send(3, 511, -512, pk(2047, -2048, 2'b11), pk(2047, -2048, 2'b11));
    repeat (4) @(posedge clk);
    #1;
    check("sat_count_two", sat_count_a, 16'd2);

    // Clear lands on the same edge as another saturating handshake.
    send(3, 511, -512, pk(2047, -2048, 2'b11), pk(2047, -2048, 2'b11));
    @(posedge clk);
    #1;
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    @(negedge clk);
    check("sat_clr_wins", sat_count_a, 16'd0);
    @(posedge clk);
    #1;

    send(2, -1, 5, pk(-4, 20, 2'b00), pk(-4, 20, 2'b00));
    // Select 7: out of range for the 5-entry table, wraps to 3 on the 2-bit port.
    send(7, 100, 0, pk(794, 0, 2'b00), pk(187, 0, 2'b00));
    repeat (4) @(posedge clk);
    #1;

    // Five-beat stream with a three-cycle output stall.
    fork
      begin
        send(1, 50, -50, pk(-94, 94, 2'b00), pk(-94, 93, 2'b00));
        send(2, 100, -100, pk(400, -400, 2'b00), pk(400, -400, 2'b00));
        send(3, 20, -20, pk(159, -159, 2'b00), pk(158, -159, 2'b00));
        send(0, 1, -1, pk(2, -2, 2'b00), pk(1, -2, 2'b00));
        send(3, 258, -258, pk(2047, -2048, 2'b01), pk(2047, -2048, 2'b00));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_out_valid", out_valid_a, 1'b1);
          check("stall_in_ready", in_ready_a, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Counter stickiness: b clamps at 3, a keeps counting.
    repeat (3) send(3, 511, -512, pk(2047, -2048, 2'b11), pk(2047, -2048, 2'b11));
    repeat (5) @(posedge clk);
    #1;
    check("sat_sticky_b", sat_count_b, 2'd3);
    check("sat_count_a_total", sat_count_a, 16'd7);

    // Reset with two beats in flight.
    send(0, 100, -100, pk(188, -187, 2'b00), pk(187, -188, 2'b00));
    send(2, -1, 5, pk(-4, 20, 2'b00), pk(-4, 20, 2'b00));
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async_valid", out_valid_a, 1'b0);
    check("rst_async_data", out_data_a, 24'h0);
    check("rst_async_count", sat_count_a, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    send(2, -1, 5, pk(-4, 20, 2'b00), pk(-4, 20, 2'b00));

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
